loop_counter: RTL and testbench
===============================

# loop_counter

Two-level loadable down-counter sequencer for the blitter address/loop datapath. Holds inner and outer reload registers and decrements the inner count on each `STEP`. On inner terminal count it reloads the inner counter and decrements the outer count; the final step raises a one-cycle `DONE`. It sits directly downstream of the bit-slice counter chain: it consumes the chain's borrow-style terminal count and produces the load/enable strobes that the next stage uses.

## Interface
- `WIDTH`, default 8: width of the inner and outer counters and reload registers.
- `MasterClock` in 1: sole clock; all state updates on its rising edge.
- `RESET` in 1: synchronous, active-high reset.
- `DIN` in WIDTH: reload value for `LDINNER`/`LDOUTER`.
- `LDINNER` in 1: load the inner reload register from `DIN`.
- `LDOUTER` in 1: load the outer reload register from `DIN`.
- `START` in 1: begin a job; honoured only in IDLE.
- `STEP` in 1: advance one inner count; honoured only in RUN.
- `ICNT` out WIDTH: current inner count.
- `OCNT` out WIDTH: current outer count.
- `ITC` out 1: inner terminal count, combinational, for the current cycle's step.
- `BUSY` out 1: high in RUN.
- `DONE` out 1: one-cycle pulse when a job ends.

## Operation
- States are IDLE, RUN and FINISH.
- IDLE:
  - `LDINNER` writes both `IREL` and `ICNT`.
  - `LDOUTER` writes both `OREL` and `OCNT`.
  - `START` moves to RUN.
  - If `LD*` and `START` arrive in the same cycle, the job runs with the newly loaded `DIN`.
- RUN:
  - `STEP` decrements `ICNT` modulo 2^WIDTH.
  - `ITC = BUSY & STEP & (ICNT == 1)`.
  - On `ITC`, `ICNT` reloads from `IREL` instead of decrementing, and `OCNT` decrements.
  - On `ITC` with `OCNT == 1`, the block moves to FINISH; `ICNT` reloads and `OCNT` reloads from `OREL`, ready for a re-`START`.
- FINISH: `DONE = 1` and `BUSY = 0` for one cycle, then IDLE unconditionally.
- A value of 0 means 2^WIDTH. The decrement from 0 wraps to all-ones, and terminal count is reached at 1.
- Steps per job = I × O, where I and O are the effective values.
- `LD*` in RUN or FINISH writes only the reload register. The new value takes effect at the next reload of that counter.
- `LDINNER` coincident with `ITC`: the reload uses `DIN`, not the old `IREL`. The same rule applies to `LDOUTER` at the final step.
- `START` in RUN or FINISH is ignored. `STEP` outside RUN is ignored, and `ITC` stays 0.

## Timing
- Reset values: `ICNT = 0`, `OCNT = 0`, `IREL = 0`, `OREL = 0`, `BUSY = 0`, `DONE = 0`, `ITC = 0`; state IDLE.
- `RESET` has priority over all inputs. `RESET` mid-RUN returns to IDLE next edge, with no `DONE`.
- `START` sampled at edge n: `BUSY = 1` from cycle n+1. A `STEP` in cycle n+1 is counted.
- `STEP` at edge n: counts are visible at n+1.
- `ITC` is combinational in the same cycle as the qualifying `STEP`.
- Final `STEP` at edge n: `DONE = 1` and `BUSY = 0` in cycle n+1; IDLE in n+2.
- Back-to-back: `START` is accepted in n+2 at the earliest.

## Structure
- Package `loop_counter_pkg`:
  - `state_t` enum {IDLE, RUN, FINISH}.
  - Default width constant.
- Sub-module `m_DNCNT`: a WIDTH-bit down counter with reload register and ports load, enable, reload-on-tc and tc. It is instantiated twice, for inner and outer.
- The top level holds the FSM and the `ITC`/`DONE` logic only.

## Test plan
- Reset: drive random inputs with `RESET` high → all outputs 0 and `BUSY = 0` for the whole reset.
- I=3, O=2, `START`, then `STEP` every cycle:
  - `ICNT` runs 3,2,1,3,2,1.
  - `ITC` on steps 3 and 6.
  - `OCNT` runs 2 to 1, then reloads to 2.
  - `DONE` is one cycle after step 6.
- I=0, O=1 → exactly 256 steps, then `DONE`; `ICNT` runs 0,255,…,1.
- I=4, O=3 with `STEP` gated 50% random → `ICNT` holds on idle cycles, total 12 steps, `DONE` once.
- I=2, O=2, `LDINNER` with `DIN=5` during RUN → first block takes 2 steps, second 5. Also `LDINNER` with `DIN=7` coincident with `ITC` → next block takes 7 steps.
- I=3, O=3, `RESET` after step 4 → IDLE next cycle, counts 0, no `DONE`. A `START` in RUN is ignored and does not restart the counts.

Source files
------------

// File: rtl/loop_counter_pkg.sv
// Shared types and constants for the two-level loop counter sequencer.
package loop_counter_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FINISH = 2'd2
  } state_t;

endpackage

// File: rtl/loop_counter_if.sv
// Control/status bundle between the loop counter and its upstream controller.
interface loop_counter_if #(
  parameter int WIDTH = loop_counter_pkg::DEFAULT_WIDTH
);
  import loop_counter_pkg::*;

  // Strobes are level-sampled on every rising edge; there is no back-pressure,
  // each high cycle is one request and the FSM decides whether it is honoured.
  logic [WIDTH-1:0] DIN;
  logic             LDINNER;
  logic             LDOUTER;
  logic             START;
  logic             STEP;
  logic [WIDTH-1:0] ICNT;
  logic [WIDTH-1:0] OCNT;
  logic             ITC;
  logic             BUSY;
  logic             DONE;
  state_t           state;

  modport master (
    output DIN, LDINNER, LDOUTER, START, STEP,
    input  ICNT, OCNT, ITC, BUSY, DONE, state
  );

  modport slave (
    input  DIN, LDINNER, LDOUTER, START, STEP,
    output ICNT, OCNT, ITC, BUSY, DONE, state
  );

endinterface

// File: rtl/m_DNCNT.sv
// WIDTH-bit down counter with its own reload register; terminal count at 1,
// a count of 0 stands for 2^WIDTH and wraps to all-ones on decrement.
module m_DNCNT #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             load,
  input  logic             load_cnt,
  input  logic             enable,
  input  logic             reload,
  output logic             tc,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] rel;
  logic [WIDTH-1:0] reload_val;

  // A load landing on the reload edge must win over the stale register.
  assign reload_val = load ? din : rel;
  assign tc         = (count == WIDTH'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      rel   <= '0;
      count <= '0;
    end else begin
      if (load) begin
        rel <= din;
      end
      if (load && load_cnt) begin
        count <= din;
      end else if (reload) begin
        count <= reload_val;
      end else if (enable) begin
        count <= count - WIDTH'(1);
      end
    end
  end

endmodule

// File: rtl/loop_counter.sv
// Two-level loop sequencer: inner count steps on STEP, outer count steps on
// inner terminal count, DONE pulses for one cycle after the final step.
module loop_counter
  import loop_counter_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic           MasterClock,
  input  logic           RESET,
  loop_counter_if.slave  bus
);

  state_t           state;
  logic             busy_q;
  logic             done_q;
  logic             idle;
  logic             itc;
  logic             last_step;
  logic             inner_tc;
  logic             outer_tc;
  logic [WIDTH-1:0] icnt;
  logic [WIDTH-1:0] ocnt;

  assign idle      = (state == IDLE);
  assign itc       = busy_q & bus.STEP & inner_tc & ~RESET;
  assign last_step = itc & outer_tc;

  m_DNCNT #(.WIDTH(WIDTH)) u_inner (
    .clk      (MasterClock),
    .rst      (RESET),
    .din      (bus.DIN),
    .load     (bus.LDINNER),
    .load_cnt (idle),
    .enable   (busy_q & bus.STEP),
    .reload   (itc),
    .tc       (inner_tc),
    .count    (icnt)
  );

  // The outer counter advances once per inner wrap and rearms on the last one.
  m_DNCNT #(.WIDTH(WIDTH)) u_outer (
    .clk      (MasterClock),
    .rst      (RESET),
    .din      (bus.DIN),
    .load     (bus.LDOUTER),
    .load_cnt (idle),
    .enable   (itc),
    .reload   (last_step),
    .tc       (outer_tc),
    .count    (ocnt)
  );

  always_ff @(posedge MasterClock) begin
    if (RESET) begin
      state  <= IDLE;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done_q <= 1'b0;
          if (bus.START) begin
            state  <= RUN;
            busy_q <= 1'b1;
          end
        end
        RUN: begin
          if (last_step) begin
            state  <= FINISH;
            busy_q <= 1'b0;
            done_q <= 1'b1;
          end
        end
        FINISH: begin
          state  <= IDLE;
          busy_q <= 1'b0;
          done_q <= 1'b0;
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
          done_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.ICNT  = icnt;
  assign bus.OCNT  = ocnt;
  assign bus.ITC   = itc;
  assign bus.BUSY  = busy_q;
  assign bus.DONE  = done_q;
  assign bus.state = state;

endmodule

// File: tb/tb_loop_counter.sv
// Bench for loop_counter: directed jobs plus random traffic against a
// cycle-level reference model built from effective-count arithmetic.
module tb_loop_counter;
  import loop_counter_pkg::*;

  localparam int W   = 8;
  localparam int MOD = 256;
  localparam int SW  = 32;
  localparam int M_IDLE   = 0;
  localparam int M_RUN    = 1;
  localparam int M_FINISH = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  loop_counter_if #(.WIDTH(W)) bus();

  loop_counter #(.WIDTH(W)) dut (
    .MasterClock (clk),
    .RESET       (rst),
    .bus         (bus)
  );

  // ---------------- scoreboard / model state ----------------
  int n_vec = 0;
  int n_err = 0;
  logic [SW-1:0] exp_q[$];

  int m_mode    = M_IDLE;
  int m_icnt    = 0;
  int m_ocnt    = 0;
  int m_irel    = 0;
  int m_orel    = 0;
  int job_steps = 0;
  int done_seen = 0;

  task automatic check(input string tag, input logic [SW-1:0] obs, input logic [SW-1:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int dec(input int v);
    return (v + MOD - 1) % MOD;
  endfunction

  // ---------------- driver: one cycle, check mid-cycle, model at edge ----------------
  task automatic apply(input logic r, input int din, input logic ldi, input logic ldo,
                       input logic st, input logic sp);
    logic exp_itc;
    rst         = r;
    bus.DIN     = din[W-1:0];
    bus.LDINNER = ldi;
    bus.LDOUTER = ldo;
    bus.START   = st;
    bus.STEP    = sp;
    @(negedge clk);
    exp_itc = !r && (m_mode == M_RUN) && sp && (m_icnt == 1);
    check("icnt", SW'(bus.ICNT), SW'(m_icnt));
    check("ocnt", SW'(bus.OCNT), SW'(m_ocnt));
    check("busy", SW'(bus.BUSY), SW'(m_mode == M_RUN));
    check("done", SW'(bus.DONE), SW'(m_mode == M_FINISH));
    check("itc",  SW'(bus.ITC),  SW'(exp_itc));
    if (m_mode == M_FINISH) begin
      done_seen++;
      if (exp_q.size() > 0) check("job_steps", SW'(job_steps), exp_q.pop_front());
    end
    @(posedge clk);
    if (r) begin
      m_mode = M_IDLE; m_icnt = 0; m_ocnt = 0; m_irel = 0; m_orel = 0;
    end else begin
      case (m_mode)
        M_IDLE: begin
          if (ldi) begin m_irel = din; m_icnt = din; end
          if (ldo) begin m_orel = din; m_ocnt = din; end
          if (st) begin m_mode = M_RUN; job_steps = 0; end
        end
        M_RUN: begin
          if (sp) begin
            job_steps++;
            if (m_icnt == 1) begin
              m_icnt = ldi ? din : m_irel;
              if (m_ocnt == 1) begin
                m_ocnt = ldo ? din : m_orel;
                m_mode = M_FINISH;
              end else begin
                m_ocnt = dec(m_ocnt);
              end
            end else begin
              m_icnt = dec(m_icnt);
            end
          end
          if (ldi) m_irel = din;
          if (ldo) m_orel = din;
        end
        default: begin
          if (ldi) m_irel = din;
          if (ldo) m_orel = din;
          m_mode = M_IDLE;
        end
      endcase
    end
    #1;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) apply(1'b0, $urandom_range(0, 255), 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic setup_job(input int i_val, input int o_val);
    apply(1'b0, i_val, 1'b1, 1'b0, 1'b0, 1'b0);
    apply(1'b0, o_val, 1'b0, 1'b1, 1'b0, 1'b0);
    apply(1'b0, 0, 1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic steps(input int n);
    repeat (n) apply(1'b0, $urandom_range(0, 255), 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int d0;
    int k;
    bus.DIN = '0; bus.LDINNER = 1'b0; bus.LDOUTER = 1'b0;
    bus.START = 1'b0; bus.STEP = 1'b0;
    @(posedge clk);
    #1;

    // Reset held with random inputs: everything must stay zero.
    repeat (6) apply(1'b1, $urandom_range(0, 255), 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 1)));

    // I=3, O=2 stepping every cycle.
    setup_job(3, 2);
    exp_q.push_back(SW'(3 * 2));
    steps(6);
    idle_cycles(2);

    // I=0 means 256 inner counts.
    setup_job(0, 1);
    exp_q.push_back(SW'(256));
    steps(256);
    idle_cycles(2);

    // I=4, O=3 with half the cycles stepping.
    setup_job(4, 3);
    exp_q.push_back(SW'(4 * 3));
    d0 = done_seen;
    k  = 0;
    while (done_seen == d0 && k < 200) begin
      apply(1'b0, $urandom_range(0, 255), 1'b0, 1'b0, 1'b0, 1'($urandom_range(0, 1)));
      k++;
    end
    check("t3_budget", SW'(k < 200), SW'(1));
    idle_cycles(3);
    check("t3_done_once", SW'(done_seen - d0), SW'(1));

    // Reload register rewritten mid-run: blocks of 2 then 5.
    setup_job(2, 2);
    exp_q.push_back(SW'(2 + 5));
    steps(1);
    apply(1'b0, 5, 1'b1, 1'b0, 1'b0, 1'b0);
    steps(6);
    idle_cycles(2);

    // Load coincident with inner terminal count: blocks of 2 then 7.
    setup_job(2, 2);
    exp_q.push_back(SW'(2 + 7));
    steps(1);
    apply(1'b0, 7, 1'b1, 1'b0, 1'b0, 1'b1);
    steps(7);
    idle_cycles(2);

    // Ignored START in RUN, then reset after step 4: no DONE.
    setup_job(3, 3);
    d0 = done_seen;
    steps(1);
    apply(1'b0, 0, 1'b0, 1'b0, 1'b1, 1'b1);
    steps(2);
    apply(1'b1, 0, 1'b0, 1'b0, 1'b0, 1'b1);
    idle_cycles(4);
    check("t5_no_done", SW'(done_seen - d0), SW'(0));

    // Random traffic.
    for (int n = 0; n < 3000; n++) begin
      int din;
      din = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 4);
      apply(1'($urandom_range(0, 99) == 0), din,
            1'($urandom_range(0, 19) == 0), 1'($urandom_range(0, 19) == 0),
            1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 9) < 7));
    end

    check("exp_q_empty", SW'(exp_q.size()), SW'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
